uart_rx_framer: RTL

//  Parametrised UART receiver with a small output FIFO; successor to the fixed 8N1 front end of the top level.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_framer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encoding and counter width helpers.
// Shared by uart_rx_framer and uart_rx_fifo.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH x W synchronous FIFO, first-word fall-through head.
// A push into a full FIFO is dropped and reported unless a pop frees a slot.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overrun
);
    localparam int AW = cnt_w(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic          ovr_q;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign pop   = out_ready && (level_q != '0);
    assign full  = (level_q == LW'(DEPTH));
    assign wr_en = push && (!full || pop);

    // Storage, pointers, occupancy and the overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_q] <= push_data;
                wr_q      <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + LW'(wr_en) - LW'(pop);
            ovr_q   <= push && full && !pop;
        end
    end

    assign out_data  = mem[rd_q];
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver feeding a small output FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_framer
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         busy,
    output logic                         err_frame,
    output logic                         err_overrun,
    output logic                         err_parity
);
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int TW  = cnt_w(OVERSAMPLE);
    localparam int BW  = cnt_w(DATA_BITS + 1);
    localparam bit OS1 = (OVERSAMPLE == 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   rx_s;
    state_t                 state_q;
    state_t                 state_d;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_bad_q;
    logic                   push_q;
    logic                   err_frame_q;
    logic                   err_parity_q;
    logic                   samp;

    // Synchroniser; fill_q marks when sync_q holds only post-reset samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign samp = (tick_q == T_LAST);

    // Next-state logic of the frame FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (fill_q[SYNC_STAGES-1] && rx_s) state_d = IDLE;
            IDLE:      if (!rx_s) state_d = START;
            START: begin
                if (OS1) state_d = DATA;
                else if (tick_q == T_HALF) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (samp && bit_q == D_LAST) state_d = PAR_EN ? PARITY : STOP;
            end
            PARITY:    if (samp) state_d = STOP;
            STOP: begin
                if (samp) begin
                    if (!rx_s) state_d = WAIT_IDLE;
                    else if (bit_q == S_LAST) state_d = IDLE;
                end
            end
            default:   state_d = WAIT_IDLE;
        endcase
    end

    // State register, counters, shifter and frame result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            push_q       <= 1'b0;
            err_frame_q  <= 1'b0;
            err_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            push_q       <= 1'b0;
            err_frame_q  <= 1'b0;
            err_parity_q <= 1'b0;
            tick_q <= (state_d != state_q || samp) ? '0 : tick_q + 1'b1;
            if (state_q == START && OS1) begin
                shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                bit_q   <= BW'(1);
            end else if (state_d != state_q) begin
                bit_q <= '0;
            end else if (samp && (state_q == DATA || state_q == STOP)) begin
                bit_q <= bit_q + 1'b1;
            end
            if (state_q == DATA && samp)
                shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
            if (state_q == IDLE) par_bad_q <= 1'b0;
            if (state_q == PARITY && samp)
                par_bad_q <= ((^shreg_q) ^ rx_s) != (PARITY_ODD != 0);
            if (state_q == STOP && samp) begin
                if (!rx_s) err_frame_q <= 1'b1;
                else if (bit_q == S_LAST) begin
                    if (par_bad_q) err_parity_q <= 1'b1;
                    else push_q <= 1'b1;
                end
            end
        end
    end

    uart_rx_fifo #(
        .W     (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (shreg_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (fifo_level),
        .overrun   (err_overrun)
    );

    assign busy       = (state_q != IDLE) && (state_q != WAIT_IDLE);
    assign err_frame  = err_frame_q;
    assign err_parity = PAR_EN & err_parity_q;

endmodule
